program_counter: RTL and testbench

- Architectural program-counter register for the RV32I single-cycle CPU (reused as the IF-stage PC in the 5-stage pipeline).
- Holds the address of the instruction being fetched, loads the next-PC value chosen by the branch/jump mux each clock, and supplies PC+4 and alignment status to fetch and control logic.
- Sits between the next-PC mux (input) and instruction memory / branch adder (outputs).

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_incrementer.sv | 26 ++
 rtl/program_counter.sv | 95 +++++++++
 tb/tb_program_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the program-counter slice: default
//               widths and reset vector, the address type, the fetch
//               increment and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Defaults for the XLEN / RESET_VECTOR / IALIGN_BYTES parameters of the
  // modules that import this package. They carry a DEFAULT_ prefix so that
  // they never shadow the module parameters of the same role.
  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_IALIGN_BYTES = 4;

  // Address type for the default datapath width.
  typedef logic [DEFAULT_XLEN-1:0] addr_t;

  // Byte distance between consecutive RV32I instructions.
  localparam int PC_INCR = 4;

  // Number of low address bits that must be zero for an access aligned to
  // 'bytes'. 'bytes' is expected to be a power of two.
  function automatic int align_bits(input int bytes);
    return $clog2(bytes);
  endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_incrementer.sv
`default_nettype none
// ============================================================================
// Module      : pc_incrementer
// Description : Combinational address + PC_INCR adder. The sum wraps modulo
//               2^XLEN (the carry out is discarded). It is shared by the
//               program counter and the branch unit.
// Ports       : i_addr  [XLEN-1:0]  input address
//               o_sum   [XLEN-1:0]  i_addr + PC_INCR, wrapped
// Revision    : 1.0 - initial release
// ============================================================================
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] o_sum
);

  localparam logic [XLEN-1:0] c_INCR = XLEN'(PC_INCR);

  // The XLEN-wide result keeps only the low bits, so wrap-around is implicit.
  assign o_sum = i_addr + c_INCR;

endmodule : pc_incrementer
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Architectural PC register for the RV32I core. It loads the
//               next-PC mux output on each enabled rising clock edge, holds
//               its value when stalled, and supplies PC+4 and a misalignment
//               flag. The reset is asynchronous and active-low.
// Ports       : clk         system clock, rising edge
//               rst         asynchronous reset, active low
//               en          1 = load next_pc at the edge, 0 = hold
//               next_pc     [XLEN-1:0] next fetch address
//               pc          [XLEN-1:0] current fetch address (registered)
//               pc_plus4    [XLEN-1:0] pc + 4, wrapped
//               misaligned  1 when the low log2(IALIGN_BYTES) bits of pc are set
//               prev_pc     [XLEN-1:0] pc before the last load  (PC_TRACE_EN)
//               load_count  [31:0]     accepted loads, wrapping (PC_TRACE_EN)
// Macro       : PC_TRACE_EN - when defined, adds prev_pc and load_count.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              IALIGN_BYTES = DEFAULT_IALIGN_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
`ifdef PC_TRACE_EN
  ,
  output logic [XLEN-1:0] prev_pc,
  output logic [31:0]     load_count
`endif
);

  localparam int c_ALIGN_BITS = align_bits(IALIGN_BYTES);

  // Reject alignment settings that cannot describe an instruction boundary.
  generate
    if ((IALIGN_BYTES < 2) || ((IALIGN_BYTES & (IALIGN_BYTES - 1)) != 0)) begin : g_bad_ialign
      $error("program_counter: IALIGN_BYTES must be a power of two and at least 2");
    end
  endgenerate

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;

  // next_pc is stored exactly as presented; misaligned targets are flagged
  // downstream rather than corrected here. Reset has priority over any load,
  // including one coinciding with the same clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VECTOR;
    end else if (en) begin
      r_pc <= next_pc;
    end
  end

  pc_incrementer #(
    .XLEN   (XLEN)
  ) u_pc_incrementer (
    .i_addr (r_pc),
    .o_sum  (w_pc_plus4)
  );

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misaligned = |r_pc[c_ALIGN_BITS-1:0];

`ifdef PC_TRACE_EN
  logic [XLEN-1:0] r_prev_pc;
  logic [31:0]     r_load_count;

  // Trace state advances on exactly the same edges on which r_pc loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_pc    <= RESET_VECTOR;
      r_load_count <= 32'd0;
    end else if (en) begin
      r_prev_pc    <= r_pc;
      r_load_count <= r_load_count + 32'd1;
    end
  end

  assign prev_pc    = r_prev_pc;
  assign load_count = r_load_count;
`endif

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Directed plus random bench for program_counter. Expected PC
//               values are queued when stimulus is applied and popped for
//               comparison after the clock edge.
// Macro       : PC_TRACE_EN - also checks prev_pc and load_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
`ifdef PC_TRACE_EN
  logic [31:0] prev_pc;
  logic [31:0] load_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_prev;
  logic [31:0] m_cnt;
  logic [31:0] exp_q[$];

  program_counter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .next_pc    (next_pc),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
`ifdef PC_TRACE_EN
    ,
    .prev_pc    (prev_pc),
    .load_count (load_count)
`endif
  );

  // 20 ns clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against one expected pc value.
  task automatic chk_pc(input string tag, input logic [31:0] e_pc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, (e_pc[1:0] != 2'b00)});
`ifdef PC_TRACE_EN
    chk({tag, ".prev_pc"}, prev_pc, m_prev);
    chk({tag, ".load_count"}, load_count, m_cnt);
`endif
  endtask

  // Apply stimulus off-edge, predict, then compare just after the rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [31:0] np);
    logic [31:0] e_pc;
    @(negedge clk);
    rst     = r;
    en      = e;
    next_pc = np;
    if (!r) begin
      m_pc   = 32'h0;
      m_prev = 32'h0;
      m_cnt  = 32'h0;
      #1;
      chk_pc({tag, ".async"}, 32'h0);
    end else if (e) begin
      m_prev = m_pc;
      m_pc   = np;
      m_cnt  = m_cnt + 32'd1;
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e_pc = exp_q.pop_front();
      chk_pc(tag, e_pc);
    end
  endtask

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    next_pc = 32'h0;
    m_pc    = 32'h0;
    m_prev  = 32'h0;
    m_cnt   = 32'h0;

    // Asynchronous reset with no clock edge involved
    #3 rst = 1'b0;
    #1 chk_pc("reset_entry", 32'h0);

    // Held in reset, loads ignored
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Release and first load
    step("load_10", 1'b1, 1'b1, 32'h0000_0010);
    step("load_100", 1'b1, 1'b1, 32'h0000_0100);

    // Mid-cycle reset must clear pc before the next edge
    #5 rst = 1'b0;
    m_pc   = 32'h0;
    m_prev = 32'h0;
    m_cnt  = 32'h0;
    #1 chk_pc("mid_reset", 32'h0);

    // Stall
    step("load_20", 1'b1, 1'b1, 32'h0000_0020);
    step("stall_a", 1'b1, 1'b0, 32'h0000_0040);
    step("stall_b", 1'b1, 1'b0, 32'h0000_0040);
    step("unstall", 1'b1, 1'b1, 32'h0000_0040);

    // Misalignment and wrap
    step("misalign_6", 1'b1, 1'b1, 32'h0000_0006);
    step("misalign_2", 1'b1, 1'b1, 32'h0000_0102);
    step("wrap", 1'b1, 1'b1, 32'hFFFF_FFFC);

    // Trace sequence: reset, loads 4, 8, stall, C
    step("tr_reset", 1'b0, 1'b0, 32'h0);
    step("tr_4", 1'b1, 1'b1, 32'h4);
    step("tr_8", 1'b1, 1'b1, 32'h8);
    step("tr_stall", 1'b1, 1'b0, 32'h10);
    step("tr_c", 1'b1, 1'b1, 32'hC);
`ifdef PC_TRACE_EN
    chk("trace_prev_final", prev_pc, 32'h8);
    chk("trace_count_final", load_count, 32'd3);
`endif
    step("tr_reset2", 1'b0, 1'b1, 32'h44);
`ifdef PC_TRACE_EN
    chk("trace_prev_reset", prev_pc, 32'h0);
    chk("trace_count_reset", load_count, 32'd0);
`endif

    // Random cycles
    for (int i = 0; i < 25; i++) begin
      step("random", ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_program_counter
`default_nettype wire
